// File: rtl/pathfinding_pkg.sv
// Shared types and constants for the A* pathfinding engine: node records,
// slot encodings, queue command opcodes and controller states.
package pathfinding_pkg;

  localparam logic [15:0] EMPTY_ID     = 16'd0;
  localparam logic [15:0] TOMBSTONE_ID = 16'd800;
  localparam logic [15:0] COST_INF     = 16'd65000;
  localparam int          LIVE_W       = 7;

  typedef struct packed {
    logic [15:0]       heuristic;
    logic [15:0]       total_cost;
    logic [9:0][15:0]  neighbor_ids;
  } map_node;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] node_id;
    logic [15:0] parent_id;
    logic [15:0] current_cost;
    map_node     info;
  } node_info;

  typedef enum logic [1:0] {
    OP_CLEAR   = 2'b00,
    OP_RELAX   = 2'b01,
    OP_POP_MIN = 2'b10,
    OP_NOP     = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT,
    ST_EVAL,
    ST_WRITE,
    ST_RESP
  } queue_state_t;

  localparam node_info DEFAULT_NODE =
    {16'd0, 16'd0, TOMBSTONE_ID, TOMBSTONE_ID, COST_INF, 192'd0};

  function automatic node_info as_tombstone(input node_info n);
    node_info t;
    t = n;
    t.node_id = TOMBSTONE_ID;
    return t;
  endfunction

endpackage

// File: rtl/queue_controller_if.sv
// Command/response channel between the pathfinding FSM (master) and the
// open-list queue controller (slave).
interface queue_controller_if;
  import pathfinding_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  cmd_op_t              cmd_op;
  node_info             cmd_node;
  logic                 rsp_valid;
  node_info             rsp_node;
  logic                 rsp_found;
  logic                 rsp_updated;
  logic                 rsp_empty;
  logic                 rsp_full;
  logic [LIVE_W-1:0]    live_count;

  modport master (
    output cmd_valid, cmd_op, cmd_node,
    input  cmd_ready, rsp_valid, rsp_node, rsp_found, rsp_updated,
           rsp_empty, rsp_full, live_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_node,
    output cmd_ready, rsp_valid, rsp_node, rsp_found, rsp_updated,
           rsp_empty, rsp_full, live_count
  );

endinterface

// File: rtl/queue_slot_eval.sv
// Combinational classification of the RAM slot currently being scanned
// against the pending command and the running minimum.
module queue_slot_eval
  import pathfinding_pkg::*;
(
  input  logic [15:0] slot_id,
  input  logic [15:0] slot_cost,
  input  logic [15:0] cmd_id,
  input  logic [15:0] cmd_cost,
  input  logic        best_valid,
  input  logic [15:0] best_cost,
  output logic        is_empty,
  output logic        is_tomb,
  output logic        id_match,
  output logic        cmd_cheaper,
  output logic        beats_best
);

  logic is_live;

  assign is_empty    = (slot_id == EMPTY_ID);
  assign is_tomb     = (slot_id == TOMBSTONE_ID);
  assign is_live     = !is_empty && !is_tomb;
  assign id_match    = is_live && (slot_id == cmd_id);
  assign cmd_cheaper = (cmd_cost < slot_cost);
  // strict less-than keeps the earliest (lowest address) slot on ties
  assign beats_best  = is_live && (!best_valid || (slot_cost < best_cost));

endmodule

// File: rtl/queue_controller.sv
// Open-list queue sequencer: linear scan of the node RAM for CLEAR, RELAX
// and POP_MIN, with an optional single write and a one-cycle response.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   CLEAR | zeroing one slot per cycle
//   WAIT  | read address registered, RAM access in flight
//   EVAL  | ram_read_data valid for the current slot; decide/advance
//   WRITE | single RAM write of the command result
//   RESP  | rsp_valid strobe
module queue_controller
  import pathfinding_pkg::*;
#(
  parameter int MAX_NODES = 100,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  queue_controller_if.slave bus,
  output logic [ADDR_W-1:0] ram_read_address,
  input  node_info          ram_read_data,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_write_address,
  output node_info          ram_write_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NODES - 1);

  queue_state_t       state;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  node_info           rsp_node_r;
  logic               rsp_found_r;
  logic               rsp_updated_r;
  logic               rsp_empty_r;
  logic               rsp_full_r;
  logic [LIVE_W-1:0]  live_count_r;

  cmd_op_t            op_q;
  node_info           cmd_q;
  logic               free_valid;
  logic [ADDR_W-1:0]  free_addr;
  logic               best_valid;
  logic [ADDR_W-1:0]  best_addr;
  node_info           best_node;

  logic               is_empty;
  logic               is_tomb;
  logic               id_match;
  logic               cmd_cheaper;
  logic               beats_best;

  logic               free_valid_n;
  logic [ADDR_W-1:0]  free_addr_n;
  logic               best_valid_n;
  logic [ADDR_W-1:0]  best_addr_n;
  node_info           best_node_n;
  logic               scan_done;
  logic               cmd_illegal;

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_node    = rsp_node_r;
  assign bus.rsp_found   = rsp_found_r;
  assign bus.rsp_updated = rsp_updated_r;
  assign bus.rsp_empty   = rsp_empty_r;
  assign bus.rsp_full    = rsp_full_r;
  assign bus.live_count  = live_count_r;

  queue_slot_eval u_slot_eval (
    .slot_id     (ram_read_data.node_id),
    .slot_cost   (ram_read_data.current_cost),
    .cmd_id      (cmd_q.node_id),
    .cmd_cost    (cmd_q.current_cost),
    .best_valid  (best_valid),
    .best_cost   (best_node.current_cost),
    .is_empty    (is_empty),
    .is_tomb     (is_tomb),
    .id_match    (id_match),
    .cmd_cheaper (cmd_cheaper),
    .beats_best  (beats_best)
  );

  assign cmd_illegal = (bus.cmd_node.node_id == EMPTY_ID) ||
                       (bus.cmd_node.node_id == TOMBSTONE_ID);

  // Scan bookkeeping including the slot under evaluation this cycle
  always_comb begin
    free_valid_n = free_valid;
    free_addr_n  = free_addr;
    if (!free_valid && (is_empty || is_tomb)) begin
      free_valid_n = 1'b1;
      free_addr_n  = ram_read_address;
    end
    best_valid_n = best_valid;
    best_addr_n  = best_addr;
    best_node_n  = best_node;
    if (beats_best) begin
      best_valid_n = 1'b1;
      best_addr_n  = ram_read_address;
      best_node_n  = ram_read_data;
    end
    scan_done = is_empty || (ram_read_address == LAST_ADDR) ||
                ((op_q == OP_RELAX) && id_match);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      cmd_ready_r       <= 1'b1;
      rsp_valid_r       <= 1'b0;
      rsp_node_r        <= DEFAULT_NODE;
      rsp_found_r       <= 1'b0;
      rsp_updated_r     <= 1'b0;
      rsp_empty_r       <= 1'b0;
      rsp_full_r        <= 1'b0;
      live_count_r      <= '0;
      ram_read_address  <= '0;
      ram_write_enable  <= 1'b0;
      ram_write_address <= '0;
      ram_write_data    <= '0;
      op_q              <= OP_NOP;
      cmd_q             <= '0;
      free_valid        <= 1'b0;
      free_addr         <= '0;
      best_valid        <= 1'b0;
      best_addr         <= '0;
      best_node         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_r      <= 1'b0;
            rsp_node_r       <= DEFAULT_NODE;
            rsp_found_r      <= 1'b0;
            rsp_updated_r    <= 1'b0;
            rsp_empty_r      <= 1'b0;
            rsp_full_r       <= 1'b0;
            op_q             <= bus.cmd_op;
            cmd_q            <= bus.cmd_node;
            free_valid       <= 1'b0;
            best_valid       <= 1'b0;
            ram_read_address <= '0;
            case (bus.cmd_op)
              OP_CLEAR: begin
                ram_write_enable  <= 1'b1;
                ram_write_address <= '0;
                ram_write_data    <= '0;
                state             <= ST_CLEAR;
              end
              OP_RELAX: begin
                if (cmd_illegal) begin
                  rsp_valid_r <= 1'b1;
                  state       <= ST_RESP;
                end else begin
                  state <= ST_WAIT;
                end
              end
              OP_POP_MIN: state <= ST_WAIT;
              default: begin
                rsp_valid_r <= 1'b1;
                state       <= ST_RESP;
              end
            endcase
          end
        end

        ST_CLEAR: begin
          if (ram_write_address == LAST_ADDR) begin
            ram_write_enable <= 1'b0;
            live_count_r     <= '0;
            rsp_valid_r      <= 1'b1;
            state            <= ST_RESP;
          end else begin
            ram_write_address <= ram_write_address + 1'b1;
          end
        end

        ST_WAIT: state <= ST_EVAL;

        ST_EVAL: begin
          free_valid <= free_valid_n;
          free_addr  <= free_addr_n;
          best_valid <= best_valid_n;
          best_addr  <= best_addr_n;
          best_node  <= best_node_n;
          if (!scan_done) begin
            ram_read_address <= ram_read_address + 1'b1;
            state            <= ST_WAIT;
          end else if (op_q == OP_RELAX) begin
            if (id_match) begin
              rsp_found_r <= 1'b1;
              rsp_node_r  <= ram_read_data;
              if (cmd_cheaper) begin
                rsp_updated_r     <= 1'b1;
                ram_write_enable  <= 1'b1;
                ram_write_address <= ram_read_address;
                ram_write_data    <= cmd_q;
                state             <= ST_WRITE;
              end else begin
                rsp_valid_r <= 1'b1;
                state       <= ST_RESP;
              end
            end else if (free_valid_n) begin
              rsp_updated_r     <= 1'b1;
              live_count_r      <= live_count_r + 1'b1;
              ram_write_enable  <= 1'b1;
              ram_write_address <= free_addr_n;
              ram_write_data    <= cmd_q;
              state             <= ST_WRITE;
            end else begin
              rsp_full_r  <= 1'b1;
              rsp_valid_r <= 1'b1;
              state       <= ST_RESP;
            end
          end else if (best_valid_n) begin
            rsp_node_r        <= best_node_n;
            live_count_r      <= live_count_r - 1'b1;
            ram_write_enable  <= 1'b1;
            ram_write_address <= best_addr_n;
            ram_write_data    <= as_tombstone(best_node_n);
            state             <= ST_WRITE;
          end else begin
            rsp_empty_r <= 1'b1;
            rsp_valid_r <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_WRITE: begin
          ram_write_enable <= 1'b0;
          rsp_valid_r      <= 1'b1;
          state            <= ST_RESP;
        end

        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_controller.sv
// Self-checking bench for queue_controller: table of command vectors fed
// through a response scoreboard, plus fill-to-full and reset-abort sequences.
module tb_queue_controller;
  import pathfinding_pkg::*;

  localparam int MAXN = 100;

  typedef struct {
    cmd_op_t  op;
    node_info node;
    node_info exp_node;
    logic     found;
    logic     updated;
    logic     empty;
    logic     full;
    int       live;
    int       lat;
    int       writes;
    int       wr_addr;
    node_info wr_data;
    int       mem_idx;
    node_info mem_val;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  queue_controller_if bus();

  logic [6:0]   ram_ra;
  logic [6:0]   ram_wa;
  logic [271:0] ram_rd;
  logic [271:0] ram_wd;
  logic         ram_we;

  queue_controller #(.MAX_NODES(MAXN), .ADDR_W(7)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .ram_read_address  (ram_ra),
    .ram_read_data     (ram_rd),
    .ram_write_enable  (ram_we),
    .ram_write_address (ram_wa),
    .ram_write_data    (ram_wd)
  );

  logic [271:0] mem [0:127];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    ram_rd <= mem[ram_ra];
  end

  int           n_cmp = 0;
  int           n_bad = 0;
  int           edge_cnt = 0;
  int           wr_cnt = 0;
  logic         clear_ok = 1'b1;
  logic [6:0]   wr_addr_last = '0;
  logic [271:0] wr_data_last = '0;
  vec_t         exp_q[$];
  vec_t         mon_e;
  vec_t         vecs[16];

  function automatic void check(input string name, input logic [271:0] act,
                                input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h wanted %h", name, act, exp);
    end
  endfunction

  function automatic node_info mk(input int id, input int cost);
    node_info n;
    n = '0;
    n.x = 16'(id * 3);
    n.y = 16'(id + 7);
    n.node_id = 16'(id);
    n.parent_id = 16'(id + 1);
    n.current_cost = 16'(cost);
    n.info.heuristic = 16'(id * 2);
    n.info.neighbor_ids[3] = 16'(id);
    return n;
  endfunction

  function automatic node_info tomb(input node_info n);
    node_info t;
    t = n;
    t.node_id = 16'd800;
    return t;
  endfunction

  function automatic vec_t mkv(input cmd_op_t op, input node_info n, input node_info en,
                               input logic f, input logic u, input logic e, input logic fl,
                               input int live, input int lat, input int writes,
                               input int wa, input node_info wd);
    vec_t v;
    v.op = op; v.node = n; v.exp_node = en;
    v.found = f; v.updated = u; v.empty = e; v.full = fl;
    v.live = live; v.lat = lat; v.writes = writes;
    v.wr_addr = wa; v.wr_data = wd;
    v.mem_idx = -1; v.mem_val = '0;
    return v;
  endfunction

  // Write-port monitor: counts writes of the current command
  always @(posedge clk) begin
    if (!reset && ram_we) begin
      if (ram_wa != 7'(wr_cnt) || ram_wd != '0) clear_ok = 1'b0;
      wr_cnt++;
      wr_addr_last = ram_wa;
      wr_data_last = ram_wd;
    end
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid wanted none");
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_node", bus.rsp_node, mon_e.exp_node);
        check("rsp_found", bus.rsp_found, mon_e.found);
        check("rsp_updated", bus.rsp_updated, mon_e.updated);
        check("rsp_empty", bus.rsp_empty, mon_e.empty);
        check("rsp_full", bus.rsp_full, mon_e.full);
        check("live_count", bus.live_count, mon_e.live);
        check("latency", edge_cnt, mon_e.lat);
        check("write_count", wr_cnt, mon_e.writes);
        if (mon_e.writes == 1) begin
          check("write_addr", wr_addr_last, mon_e.wr_addr);
          check("write_data", wr_data_last, mon_e.wr_data);
        end
        if (mon_e.op == OP_CLEAR) check("clear_pattern", clear_ok, 1'b1);
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int guard;
    wait_ready();
    if (bus.cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got cmd_ready=0 wanted 1");
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_node  = v.node;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    edge_cnt = 1;
    wr_cnt = 0;
    clear_ok = 1'b1;
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 2000) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      guard++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got no rsp_valid wanted one");
      exp_q.delete();
      return;
    end
    @(negedge clk);
    #1;
    if (v.mem_idx >= 0) check("ram_slot", mem[v.mem_idx], v.mem_val);
  endtask

  initial begin
    node_info z, n5, n7, n9, n7b, n11, n12;
    int guard;
    z   = '0;
    n5  = mk(5, 40);
    n7  = mk(7, 20);
    n9  = mk(9, 20);
    n7b = mk(7, 10);
    n11 = mk(11, 50);
    n12 = mk(12, 50);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_node  = '0;

    #2 reset = 1'b1;
    #10;
    check("reset_cmd_ready", bus.cmd_ready, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_node", bus.rsp_node, DEFAULT_NODE);
    check("reset_rsp_flags", {bus.rsp_found, bus.rsp_updated, bus.rsp_empty, bus.rsp_full}, 4'b0);
    check("reset_live_count", bus.live_count, 7'd0);
    check("reset_write_en", ram_we, 1'b0);
    check("reset_addresses", {ram_ra, ram_wa}, 14'd0);
    check("reset_write_data", ram_wd, 272'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = mkv(OP_CLEAR,   z,            DEFAULT_NODE, 0,0,0,0, 0, MAXN+1, MAXN, 0, z);
    vecs[1]  = mkv(OP_RELAX,   n5,           DEFAULT_NODE, 0,1,0,0, 1, 4,  1, 0, n5);
    vecs[2]  = mkv(OP_RELAX,   n7,           DEFAULT_NODE, 0,1,0,0, 2, 6,  1, 1, n7);
    vecs[3]  = mkv(OP_RELAX,   n9,           DEFAULT_NODE, 0,1,0,0, 3, 8,  1, 2, n9);
    vecs[4]  = mkv(OP_RELAX,   mk(7, 30),    n7,           1,0,0,0, 3, 5,  0, 0, z);
    vecs[5]  = mkv(OP_RELAX,   n7b,          n7,           1,1,0,0, 3, 6,  1, 1, n7b);
    vecs[6]  = mkv(OP_POP_MIN, z,            n7b,          0,0,0,0, 2, 10, 1, 1, tomb(n7b));
    vecs[7]  = mkv(OP_POP_MIN, z,            n9,           0,0,0,0, 1, 10, 1, 2, tomb(n9));
    vecs[8]  = mkv(OP_POP_MIN, z,            n5,           0,0,0,0, 0, 10, 1, 0, tomb(n5));
    vecs[9]  = mkv(OP_POP_MIN, z,            DEFAULT_NODE, 0,0,1,0, 0, 9,  0, 0, z);
    vecs[10] = mkv(OP_RELAX,   n11,          DEFAULT_NODE, 0,1,0,0, 1, 10, 1, 0, n11);
    vecs[11] = mkv(OP_RELAX,   mk(0, 5),     DEFAULT_NODE, 0,0,0,0, 1, 1,  0, 0, z);
    vecs[12] = mkv(OP_RELAX,   mk(800, 5),   DEFAULT_NODE, 0,0,0,0, 1, 1,  0, 0, z);
    vecs[13] = mkv(OP_NOP,     n5,           DEFAULT_NODE, 0,0,0,0, 1, 1,  0, 0, z);
    vecs[14] = mkv(OP_RELAX,   n12,          DEFAULT_NODE, 0,1,0,0, 2, 10, 1, 1, n12);
    vecs[15] = mkv(OP_POP_MIN, z,            n11,          0,0,0,0, 1, 10, 1, 0, tomb(n11));
    vecs[6].mem_idx = 1;  vecs[6].mem_val = tomb(n7b);
    vecs[8].mem_idx = 0;  vecs[8].mem_val = tomb(n5);
    vecs[10].mem_idx = 0; vecs[10].mem_val = n11;
    vecs[11].mem_idx = 3; vecs[11].mem_val = z;

    for (int i = 0; i < 16; i++) run_cmd(vecs[i]);

    // Fill every slot, then probe full, last-slot match and last-slot reuse
    run_cmd(mkv(OP_CLEAR, z, DEFAULT_NODE, 0,0,0,0, 0, MAXN+1, MAXN, 0, z));
    for (int i = 0; i < MAXN; i++)
      run_cmd(mkv(OP_RELAX, mk(100 + i, 1000 + i), DEFAULT_NODE, 0,1,0,0,
                  i + 1, 2 * (i + 1) + 2, 1, i, mk(100 + i, 1000 + i)));
    run_cmd(mkv(OP_RELAX, mk(300, 7), DEFAULT_NODE, 0,0,0,1, MAXN, 2*MAXN + 1, 0, 0, z));
    run_cmd(mkv(OP_RELAX, mk(150, 5000), mk(150, 1050), 1,0,0,0, MAXN, 2*51 + 1, 0, 0, z));
    run_cmd(mkv(OP_RELAX, mk(199, 10), mk(199, 1099), 1,1,0,0, MAXN, 2*MAXN + 2, 1, 99, mk(199, 10)));
    run_cmd(mkv(OP_POP_MIN, z, mk(199, 10), 0,0,0,0, MAXN-1, 2*MAXN + 2, 1, 99, tomb(mk(199, 10))));
    run_cmd(mkv(OP_RELAX, mk(300, 7), DEFAULT_NODE, 0,1,0,0, MAXN, 2*MAXN + 2, 1, 99, mk(300, 7)));

    // Reset in the middle of a CLEAR
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_CLEAR;
    bus.cmd_node  = '0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!(ram_we === 1'b1 && ram_wa == 7'd40) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("clear_at_slot40_we", {ram_we, ram_wa}, {1'b1, 7'd40});
    #1 reset = 1'b1;
    #1;
    check("abort_write_en_async", ram_we, 1'b0);
    check("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check("abort_live_count", bus.live_count, 7'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
    check("post_reset_live_count", bus.live_count, 7'd0);
    run_cmd(mkv(OP_CLEAR, z, DEFAULT_NODE, 0,0,0,0, 0, MAXN+1, MAXN, 0, z));
    run_cmd(mkv(OP_RELAX, n5, DEFAULT_NODE, 0,1,0,0, 1, 4, 1, 0, n5));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
